// File: rtl/sleep_ctrl_unit.sv
// sleep_ctrl_unit
// Core sleep controller. It takes a sleep request from the core over APB and
// waits until the core has been idle for IDLE_CYCLES consecutive cycles. It
// then gates the core clock off. The clock comes back one cycle after an
// enabled wake source (irq_i or event_i) is seen high. It also counts the
// cycles spent asleep.
//
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   PADDR/PWDATA/PWRITE  APB request (PSEL/PENABLE qualify it)
//   PRDATA               APB read data, valid in the access cycle, else 0
//   PREADY, PSLVERR      tied to 1 / 0 (zero wait states, never errors)
//   irq_i, event_i       wake sources from the interrupt / event service units
//   core_busy_i          core still has outstanding transactions
//   core_clk_en_o        core clock-gate enable (low only while asleep)
//   sleep_o              high only while asleep
//
// Register map (word index PADDR[3:2], upper address bits must be zero):
//   0 CTRL       W  bit0=1 requests sleep; reads 0
//   1 STATUS     R  [1:0] FSM state, [2] wake_cond
//   2 WAKE_MASK  RW [0] wake on irq, [1] wake on event
//   3 SLEEP_CNT  R  cycles asleep; any write clears it
module sleep_ctrl_unit #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int IDLE_CYCLES    = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic                      irq_i,
  input  logic                      event_i,
  input  logic                      core_busy_i,
  output logic                      core_clk_en_o,
  output logic                      sleep_o
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_WAIT_IDLE = 2'd1,
    ST_SLEEP     = 2'd2,
    ST_WAKE      = 2'd3
  } state_t;

  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [IDLE_W:0] IDLE_TARGET = (IDLE_W + 1)'(IDLE_CYCLES);

  state_t                state;
  logic [IDLE_W-1:0]     idle_cnt;
  logic [IDLE_W:0]       idle_cnt_inc;
  logic [1:0]            wake_mask;
  logic [CNT_WIDTH-1:0]  sleep_cnt;

  logic       apb_wr;
  logic       apb_rd;
  logic       addr_hit;
  logic [1:0] reg_idx;
  logic       wake_cond;
  logic       sleep_req;
  logic       idle_done;
  logic       unused_bits;

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  assign apb_wr   = PSEL & PENABLE & PWRITE;
  assign apb_rd   = PSEL & PENABLE & ~PWRITE;
  // Only the first four words of the slave are mapped; everything else aliases to nothing.
  assign addr_hit = (PADDR[APB_ADDR_WIDTH-1:4] == '0);
  assign reg_idx  = PADDR[3:2];

  assign wake_cond = (wake_mask[0] & irq_i) | (wake_mask[1] & event_i);
  assign sleep_req = apb_wr & addr_hit & (reg_idx == 2'd0) & PWDATA[0];

  // The idle count includes the current cycle, so the FSM leaves WAIT_IDLE on
  // the cycle that completes IDLE_CYCLES consecutive non-busy cycles.
  assign idle_cnt_inc = {1'b0, idle_cnt} + (IDLE_W + 1)'(1);
  assign idle_done    = ~core_busy_i & (idle_cnt_inc >= IDLE_TARGET);

  assign unused_bits = ^{PADDR[1:0], PWDATA[31:2]};

  // Sleep FSM. The outputs are registered alongside the state so the clock
  // enable drops in the first SLEEP cycle and rises one cycle after wake_cond.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state         <= ST_RUN;
      idle_cnt      <= '0;
      core_clk_en_o <= 1'b1;
      sleep_o       <= 1'b0;
    end else begin
      idle_cnt <= '0;
      case (state)
        ST_RUN: begin
          // A request that arrives while a wake source is already pending is dropped.
          if (sleep_req && !wake_cond) begin
            state <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (wake_cond) begin
            state <= ST_RUN;
          end else if (idle_done) begin
            state         <= ST_SLEEP;
            core_clk_en_o <= 1'b0;
            sleep_o       <= 1'b1;
          end else begin
            idle_cnt <= core_busy_i ? '0 : idle_cnt_inc[IDLE_W-1:0];
          end
        end
        ST_SLEEP: begin
          if (wake_cond) begin
            state         <= ST_WAKE;
            core_clk_en_o <= 1'b1;
            sleep_o       <= 1'b0;
          end
        end
        ST_WAKE: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  // Software-visible registers. A SLEEP_CNT write beats a same-cycle increment.
  // Clearing WAKE_MASK while asleep leaves the core asleep until reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wake_mask <= 2'b11;
      sleep_cnt <= '0;
    end else begin
      if (apb_wr && addr_hit && (reg_idx == 2'd2)) begin
        wake_mask <= PWDATA[1:0];
      end
      if (apb_wr && addr_hit && (reg_idx == 2'd3)) begin
        sleep_cnt <= '0;
      end else if ((state == ST_SLEEP) && (sleep_cnt != '1)) begin
        sleep_cnt <= sleep_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Read mux. Data is returned combinationally in the access cycle only.
  always_comb begin
    PRDATA = '0;
    if (apb_rd && addr_hit) begin
      case (reg_idx)
        2'd1:    PRDATA = {29'd0, wake_cond, state};
        2'd2:    PRDATA = {30'd0, wake_mask};
        2'd3:    PRDATA[CNT_WIDTH-1:0] = sleep_cnt;
        default: PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sleep_ctrl_unit.sv
// Testbench for sleep_ctrl_unit.
// It runs a table of directed vectors for the basic sleep/wake flow, then
// hand-written multi-cycle corner sequences, then randomized traffic. The
// randomized traffic is compared against a cycle-level reference model.
module tb_sleep_ctrl_unit;

  localparam int  IDLE_CYCLES = 2;
  localparam longint CNT_MAX  = 64'h0000_0000_FFFF_FFFF;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        irq_i;
  logic        event_i;
  logic        core_busy_i;
  logic        core_clk_en_o;
  logic        sleep_o;

  int errors = 0;
  int checks = 0;

  sleep_ctrl_unit #(
    .APB_ADDR_WIDTH(12),
    .IDLE_CYCLES   (IDLE_CYCLES),
    .CNT_WIDTH     (32)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PWRITE       (PWRITE),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .PSLVERR      (PSLVERR),
    .irq_i        (irq_i),
    .event_i      (event_i),
    .core_busy_i  (core_busy_i),
    .core_clk_en_o(core_clk_en_o),
    .sleep_o      (sleep_o)
  );

  always #5 HCLK = ~HCLK;

  // Reference model: the controller mode uses the documented STATUS numbering
  // (0 run, 1 waiting for idle, 2 asleep, 3 waking). The idle test is a run
  // length of consecutive non-busy cycles.
  int          mMode;
  int          mZeroRun;
  longint      mCnt;
  logic [1:0]  mMask;
  logic        mClkEn;
  logic        mSleep;
  logic [31:0] mRd;

  logic [31:0] obsRd;
  logic        obsClkEn;
  logic        obsSleep;

  typedef struct {
    logic        sel;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        irq;
    logic        evt;
    logic        busy;
    logic        chkRd;
    logic [31:0] expRd;
    logic        expClkEn;
    logic        expSleep;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    mMode    = 0;
    mZeroRun = 0;
    mCnt     = 0;
    mMask    = 2'b11;
    mClkEn   = 1'b1;
    mSleep   = 1'b0;
  endtask

  function automatic logic modelWake(input logic irq, input logic evt);
    return (mMask[0] & irq) | (mMask[1] & evt);
  endfunction

  task automatic modelRead(input logic sel, input logic wr, input logic [11:0] addr,
                           input logic irq, input logic evt);
    logic [1:0] modeBits;
    mRd = 32'd0;
    modeBits = 2'(mMode);
    if (sel && !wr && addr[11:4] == 8'd0) begin
      case (addr[3:2])
        2'd1:    mRd = {29'd0, modelWake(irq, evt), modeBits};
        2'd2:    mRd = {30'd0, mMask};
        2'd3:    mRd = mCnt[31:0];
        default: mRd = 32'd0;
      endcase
    end
  endtask

  task automatic modelStep(input logic sel, input logic wr, input logic [11:0] addr,
                           input logic [31:0] wdata, input logic irq, input logic evt,
                           input logic busy);
    logic wk;
    logic wrHit;
    int   nxt;
    wk    = modelWake(irq, evt);
    wrHit = sel && wr && (addr[11:4] == 8'd0);
    nxt   = mMode;
    case (mMode)
      0: if (wrHit && addr[3:2] == 2'd0 && wdata[0] && !wk) begin
           nxt = 1;
           mZeroRun = 0;
         end
      1: if (wk) nxt = 0;
         else begin
           mZeroRun = busy ? 0 : mZeroRun + 1;
           if (mZeroRun >= IDLE_CYCLES) nxt = 2;
         end
      2: if (wk) nxt = 3;
      default: nxt = 0;
    endcase
    if (wrHit && addr[3:2] == 2'd3) mCnt = 0;
    else if (mMode == 2 && mCnt < CNT_MAX) mCnt = mCnt + 1;
    if (wrHit && addr[3:2] == 2'd2) mMask = wdata[1:0];
    mMode  = nxt;
    mClkEn = (nxt != 2);
    mSleep = (nxt == 2);
  endtask

  // This task is entered just after a falling edge. It drives one cycle of
  // inputs, samples PRDATA before the rising edge, and samples the registered
  // outputs at the next falling edge.
  task automatic applyStimulus(input logic sel, input logic wr, input logic [11:0] addr,
                               input logic [31:0] wdata, input logic irq, input logic evt,
                               input logic busy);
    PSEL        = sel;
    PENABLE     = sel;
    PWRITE      = wr;
    PADDR       = addr;
    PWDATA      = wdata;
    irq_i       = irq;
    event_i     = evt;
    core_busy_i = busy;
    modelRead(sel, wr, addr, irq, evt);
    #2;
    obsRd = PRDATA;
    @(posedge HCLK);
    modelStep(sel, wr, addr, wdata, irq, evt, busy);
    @(negedge HCLK);
    obsClkEn = core_clk_en_o;
    obsSleep = sleep_o;
  endtask

  task automatic idleCycle(input logic irq, input logic evt, input logic busy);
    applyStimulus(1'b0, 1'b0, 12'h000, 32'd0, irq, evt, busy);
  endtask

  task automatic writeReg(input logic [11:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b1, addr, data, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic readCheck(input string name, input logic [11:0] addr, input logic [31:0] expected);
    applyStimulus(1'b1, 1'b0, addr, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput(name, obsRd, expected);
  endtask

  task automatic checkPins(input string name, input logic expClkEn, input logic expSleep);
    checkOutput({name, "_clk_en"}, {31'd0, obsClkEn}, {31'd0, expClkEn});
    checkOutput({name, "_sleep"}, {31'd0, obsSleep}, {31'd0, expSleep});
  endtask

  function automatic vec_t mkVec(input logic sel, input logic wr, input logic [11:0] addr,
                                 input logic [31:0] wdata, input logic irq, input logic evt,
                                 input logic busy, input logic chkRd, input logic [31:0] expRd,
                                 input logic expClkEn, input logic expSleep);
    vec_t v;
    v.sel = sel; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.irq = irq; v.evt = evt; v.busy = busy;
    v.chkRd = chkRd; v.expRd = expRd; v.expClkEn = expClkEn; v.expSleep = expSleep;
    return v;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    irq_i = 1'b0; event_i = 1'b0; core_busy_i = 1'b0;
    HRESETn = 1'b0;
    modelReset();
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;

    checkOutput("reset_clk_en", {31'd0, core_clk_en_o}, 32'd1);
    checkOutput("reset_sleep", {31'd0, sleep_o}, 32'd0);
    checkOutput("reset_prdata", PRDATA, 32'd0);
    checkOutput("pready", {31'd0, PREADY}, 32'd1);
    checkOutput("pslverr", {31'd0, PSLVERR}, 32'd0);

    // Request sleep, sleep for ten cycles, wake on irq, then read and clear the count.
    vecs.push_back(mkVec(1, 0, 12'h004, 0, 0, 0, 0, 1, 32'd0, 1, 0));
    vecs.push_back(mkVec(1, 0, 12'h008, 0, 0, 0, 0, 1, 32'd3, 1, 0));
    vecs.push_back(mkVec(1, 1, 12'h000, 1, 0, 0, 0, 0, 32'd0, 1, 0));
    vecs.push_back(mkVec(1, 0, 12'h004, 0, 0, 0, 0, 1, 32'd1, 1, 0));
    vecs.push_back(mkVec(0, 0, 12'h000, 0, 0, 0, 0, 0, 32'd0, 0, 1));
    vecs.push_back(mkVec(1, 0, 12'h004, 0, 0, 0, 0, 1, 32'd2, 0, 1));
    for (int k = 0; k < 8; k++) vecs.push_back(mkVec(0, 0, 12'h000, 0, 0, 0, 0, 0, 32'd0, 0, 1));
    vecs.push_back(mkVec(1, 0, 12'h004, 0, 1, 0, 0, 1, 32'd6, 1, 0));
    vecs.push_back(mkVec(1, 0, 12'h004, 0, 0, 0, 0, 1, 32'd3, 1, 0));
    vecs.push_back(mkVec(1, 0, 12'h00C, 0, 0, 0, 0, 1, 32'd10, 1, 0));
    vecs.push_back(mkVec(1, 0, 12'h004, 0, 0, 0, 0, 1, 32'd0, 1, 0));
    vecs.push_back(mkVec(1, 1, 12'h00C, 0, 0, 0, 0, 0, 32'd0, 1, 0));
    vecs.push_back(mkVec(1, 0, 12'h00C, 0, 0, 0, 0, 1, 32'd0, 1, 0));
    vecs.push_back(mkVec(1, 0, 12'h010, 0, 0, 0, 0, 1, 32'd0, 1, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].irq, vecs[i].evt, vecs[i].busy);
      if (vecs[i].chkRd) checkOutput($sformatf("vec%0d_prdata", i), obsRd, vecs[i].expRd);
      checkPins($sformatf("vec%0d", i), vecs[i].expClkEn, vecs[i].expSleep);
    end

    // Busy pattern 1,0,1,0,0 delays sleep until two consecutive idle cycles.
    applyStimulus(1, 1, 12'h000, 32'd1, 0, 0, 1);
    checkPins("busy_req", 1, 0);
    idleCycle(0, 0, 1); checkPins("busy_c1", 1, 0);
    idleCycle(0, 0, 0); checkPins("busy_c2", 1, 0);
    idleCycle(0, 0, 1); checkPins("busy_c3", 1, 0);
    idleCycle(0, 0, 0); checkPins("busy_c4", 1, 0);
    idleCycle(0, 0, 0); checkPins("busy_c5", 0, 1);
    applyStimulus(1, 0, 12'h004, 32'd0, 0, 1, 0);
    checkOutput("busy_wake_status", obsRd, 32'd6);
    checkPins("busy_wake", 1, 0);
    idleCycle(0, 0, 0); checkPins("busy_wake_done", 1, 0);
    readCheck("busy_run_status", 12'h004, 32'd0);

    // Request with irq pending is dropped; event during WAIT_IDLE aborts even when idle would complete.
    applyStimulus(1, 1, 12'h000, 32'd1, 1, 0, 0);
    checkPins("drop_req", 1, 0);
    readCheck("drop_status", 12'h004, 32'd0);
    writeReg(12'h000, 32'd1);
    readCheck("abort_wait_status", 12'h004, 32'd1);
    idleCycle(0, 1, 0); checkPins("abort_evt", 1, 0);
    readCheck("abort_status", 12'h004, 32'd0);
    checkPins("abort_after", 1, 0);

    // Only events wake when the mask is 2'b10; a count clear during sleep wins.
    writeReg(12'h008, 32'd2);
    readCheck("mask_read", 12'h008, 32'd2);
    writeReg(12'h000, 32'd1);
    idleCycle(0, 0, 0);
    idleCycle(0, 0, 0); checkPins("mask_sleep", 0, 1);
    applyStimulus(1, 0, 12'h004, 32'd0, 1, 0, 0);
    checkOutput("mask_irq_status", obsRd, 32'd2);
    checkPins("mask_irq", 0, 1);
    applyStimulus(1, 1, 12'h00C, 32'd0, 1, 0, 0);
    checkPins("mask_clear", 0, 1);
    applyStimulus(1, 0, 12'h00C, 32'd0, 1, 0, 0);
    checkOutput("clear_wins", obsRd, 32'd0);
    readCheck("cnt_after_clear", 12'h00C, 32'd1);
    idleCycle(0, 1, 0); checkPins("mask_evt_wake", 1, 0);
    idleCycle(0, 0, 0);
    readCheck("mask_run_status", 12'h004, 32'd0);

    // Asynchronous reset in the middle of a sleep.
    writeReg(12'h000, 32'd1);
    idleCycle(0, 0, 0);
    idleCycle(0, 0, 0); checkPins("rst_sleep", 0, 1);
    #2 HRESETn = 1'b0;
    #1;
    checkOutput("rst_async_clk_en", {31'd0, core_clk_en_o}, 32'd1);
    checkOutput("rst_async_sleep", {31'd0, sleep_o}, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    modelReset();
    readCheck("rst_mask", 12'h008, 32'd3);
    readCheck("rst_status", 12'h004, 32'd0);
    checkPins("rst_after", 1, 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      logic        sel, wr, irq, evt, busy;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [1:0]  idx;
      sel   = ($urandom_range(0, 9) >= 5);
      wr    = $urandom_range(0, 1) == 1;
      idx   = 2'($urandom_range(0, 3));
      addr  = {8'd0, idx, 2'b00};
      if ($urandom_range(0, 7) == 0) addr = 12'h010 | addr;
      wdata = $urandom;
      if (idx == 2'd2) wdata[1:0] = 2'($urandom_range(1, 3));
      if (idx == 2'd0) wdata[0] = ($urandom_range(0, 3) != 0);
      irq   = ($urandom_range(0, 7) == 0);
      evt   = ($urandom_range(0, 7) == 0);
      busy  = ($urandom_range(0, 2) == 0);
      applyStimulus(sel, wr, addr, wdata, irq, evt, busy);
      checkOutput($sformatf("rand%0d_prdata", n), obsRd, mRd);
      checkOutput($sformatf("rand%0d_clk_en", n), {31'd0, obsClkEn}, {31'd0, mClkEn});
      checkOutput($sformatf("rand%0d_sleep", n), {31'd0, obsSleep}, {31'd0, mSleep});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
